// File: rtl/gf_alu_pkg.sv
// Shared opcodes, FSM encoding and opcode decode
// for the GF ALU serial driver.
package gf_alu_pkg;

  localparam logic [1:0] OP_XOR   = 2'b00;
  localparam logic [1:0] OP_AND   = 2'b01;
  localparam logic [1:0] OP_ARITH = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // bit0=XOR, bit1=AND, bit2=ARITH; reserved -> none
  function automatic logic [2:0] op_to_onehot(
    input logic [1:0] op
  );
    logic [2:0] oh;
    oh = 3'b000;
    unique case (op)
      OP_XOR:   oh = 3'b001;
      OP_AND:   oh = 3'b010;
      OP_ARITH: oh = 3'b100;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/gf_piso.sv
// Parallel-load, LSB-first shift register.
// Clears to zero whenever neither loading nor shifting.
module gf_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst)        sr <= '0;
    else if (load)  sr <= d;
    else if (shift) sr <= sr >> 1;
    else            sr <= '0;
  end

  assign q = sr[0];

endmodule

// File: rtl/gf_alu_serial_driver.sv
// Operand serializer for the bit-serial GF ALU:
// accepts a word pair, streams it LSB-first with aligned control.
module gf_alu_serial_driver
  import gf_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [1:0]       in_op,
  input  logic             in_cmpl_x,
  input  logic             in_cmpl_y,
  input  logic             in_cin,
  output logic             X,
  output logic             Y,
  output logic             Carry_in,
  output logic             End,
  output logic             Cmpl_X,
  output logic             Cmpl_Y,
  output logic             Op_XOR,
  output logic             Op_AND,
  output logic             Op_ARITH,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST =
    (GAP > 0) ? GW'(GAP - 1) : '0;

  state_t        state_q, state_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          accept;
  logic          last;
  logic          shift_on;
  logic          ready_d;

  assign accept = in_valid & in_ready;
  assign last   = (state_q == ST_SHIFT) &&
                  (bit_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          bit_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (!last) begin
          bit_d = bit_q + 1'b1;
        end else if (GAP > 0) begin
          state_d = ST_GAP;
          bit_d   = '0;
          gap_d   = '0;
        end else if (accept) begin
          bit_d = '0;
        end else begin
          state_d = ST_IDLE;
          bit_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        bit_d   = '0;
        gap_d   = '0;
      end
    endcase
  end

  // Ready is registered from next state so it lines up
  // with the state it describes.
  assign shift_on = (state_d == ST_SHIFT);
  assign ready_d  = (state_d == ST_IDLE) ||
                    (shift_on && bit_d == BIT_LAST &&
                     GAP == 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      gap_q    <= '0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      Carry_in <= 1'b0;
      End      <= 1'b0;
      Cmpl_X   <= 1'b0;
      Cmpl_Y   <= 1'b0;
      Op_XOR   <= 1'b0;
      Op_AND   <= 1'b0;
      Op_ARITH <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      in_ready <= ready_d;
      busy     <= (state_d != ST_IDLE);
      Carry_in <= accept & in_cin;
      End      <= shift_on && (bit_d == BIT_LAST);
      if (accept) begin
        Cmpl_X <= in_cmpl_x;
        Cmpl_Y <= in_cmpl_y;
        {Op_ARITH, Op_AND, Op_XOR} <=
          op_to_onehot(in_op);
      end else if (!shift_on) begin
        Cmpl_X   <= 1'b0;
        Cmpl_Y   <= 1'b0;
        Op_XOR   <= 1'b0;
        Op_AND   <= 1'b0;
        Op_ARITH <= 1'b0;
      end
    end
  end

  gf_piso #(.WIDTH(WIDTH)) u_piso_x (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (state_q == ST_SHIFT && !last),
    .d     (in_x),
    .q     (X)
  );

  gf_piso #(.WIDTH(WIDTH)) u_piso_y (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (state_q == ST_SHIFT && !last),
    .d     (in_y),
    .q     (Y)
  );

endmodule

// File: tb/tb_gf_alu_serial_driver.sv
// Directed bench: three driver instances (8/0, 8/2, 1/0)
// share one input set; outputs packed per instance.
module tb_gf_alu_serial_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_x, in_y;
  logic [1:0] in_op;
  logic       in_cmpl_x, in_cmpl_y, in_cin;

  // [10]X [9]Y [8]Cin [7]End [6]CX [5]CY
  // [4]XOR [3]AND [2]ARITH [1]busy [0]ready
  logic [10:0] o0, o2, o1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gf_alu_serial_driver #(.WIDTH(8), .GAP(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(o0[0]), .in_x(in_x), .in_y(in_y),
    .in_op(in_op), .in_cmpl_x(in_cmpl_x),
    .in_cmpl_y(in_cmpl_y), .in_cin(in_cin),
    .X(o0[10]), .Y(o0[9]), .Carry_in(o0[8]),
    .End(o0[7]), .Cmpl_X(o0[6]), .Cmpl_Y(o0[5]),
    .Op_XOR(o0[4]), .Op_AND(o0[3]),
    .Op_ARITH(o0[2]), .busy(o0[1])
  );

  gf_alu_serial_driver #(.WIDTH(8), .GAP(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(o2[0]), .in_x(in_x), .in_y(in_y),
    .in_op(in_op), .in_cmpl_x(in_cmpl_x),
    .in_cmpl_y(in_cmpl_y), .in_cin(in_cin),
    .X(o2[10]), .Y(o2[9]), .Carry_in(o2[8]),
    .End(o2[7]), .Cmpl_X(o2[6]), .Cmpl_Y(o2[5]),
    .Op_XOR(o2[4]), .Op_AND(o2[3]),
    .Op_ARITH(o2[2]), .busy(o2[1])
  );

  gf_alu_serial_driver #(.WIDTH(1), .GAP(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(o1[0]), .in_x(in_x[0:0]),
    .in_y(in_y[0:0]), .in_op(in_op),
    .in_cmpl_x(in_cmpl_x), .in_cmpl_y(in_cmpl_y),
    .in_cin(in_cin),
    .X(o1[10]), .Y(o1[9]), .Carry_in(o1[8]),
    .End(o1[7]), .Cmpl_X(o1[6]), .Cmpl_Y(o1[5]),
    .Op_XOR(o1[4]), .Op_AND(o1[3]),
    .Op_ARITH(o1[2]), .busy(o1[1])
  );

  task automatic check(input string tag,
                       input logic [10:0] got,
                       input logic [10:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks n bits of a word on u0 (and u2 if c2),
  // advancing one clock after each.
  task automatic stream(input string tag,
                        input logic [7:0] xs,
                        input logic [7:0] ys,
                        input logic [2:0] oh,
                        input logic cx, cy, ci,
                        input int n, input logic c2);
    logic [10:0] e;
    for (int k = 0; k < n; k++) begin
      e = {xs[k], ys[k], ci && k == 0, k == 7,
           cx, cy, oh, 1'b1, k == 7};
      check($sformatf("%s_b%0d", tag, k), o0, e);
      if (c2) begin
        e[0] = 1'b0;
        check($sformatf("%s_g2_b%0d", tag, k), o2, e);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    in_x = 8'hA5; in_y = 8'h3C; in_op = 2'b10;
    in_cmpl_x = 1'b0; in_cmpl_y = 1'b0; in_cin = 1'b1;
    repeat (3) tick();
    check("rst_u0", o0, 11'b000_0000_0001);
    check("rst_u2", o2, 11'b000_0000_0001);
    check("rst_u1", o1, 11'b000_0000_0001);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_u0", o0, 11'b000_0000_0001);

    // A5/3C ARITH cin=1
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    stream("arith", 8'b1010_0101, 8'b0011_1100,
           3'b001, 1'b0, 1'b0, 1'b1, 8, 1'b1);
    check("arith_done_u0", o0, 11'b000_0000_0001);
    check("gap0", o2, 11'b000_0000_0010);
    tick();
    check("gap1", o2, 11'b000_0000_0010);
    tick();
    check("gap_idle", o2, 11'b000_0000_0001);

    // back-to-back, operands change after accept
    in_x = 8'h0F; in_y = 8'hF0; in_op = 2'b00;
    in_cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_x = 8'h81; in_y = 8'h18; in_op = 2'b01;
    in_cmpl_x = 1'b1;
    stream("w1", 8'b0000_1111, 8'b1111_0000,
           3'b100, 1'b0, 1'b0, 1'b0, 8, 1'b0);
    in_valid = 1'b0;
    stream("w2", 8'b1000_0001, 8'b0001_1000,
           3'b010, 1'b1, 1'b0, 1'b0, 8, 1'b0);
    check("b2b_idle", o0, 11'b000_0000_0001);
    repeat (3) tick();
    check("b2b_idle_g2", o2, 11'b000_0000_0001);

    // reset at bit 4
    in_x = 8'hC3; in_y = 8'h81; in_op = 2'b10;
    in_cmpl_x = 1'b0; in_cmpl_y = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    stream("pre_rst", 8'b1100_0011, 8'b1000_0001,
           3'b001, 1'b0, 1'b1, 1'b0, 4, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_u0", o0, 11'b000_0000_0001);
    check("midrst_u2", o2, 11'b000_0000_0001);
    tick();
    check("midrst_noend", o0, 11'b000_0000_0001);
    in_x = 8'h5A; in_y = 8'hA5; in_op = 2'b00;
    in_cmpl_y = 1'b0; in_cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    stream("post_rst", 8'b0101_1010, 8'b1010_0101,
           3'b100, 1'b0, 1'b0, 1'b1, 8, 1'b1);
    repeat (3) tick();

    // reserved op; WIDTH=1 instance single cycle
    in_x = 8'h01; in_y = 8'h00; in_op = 2'b11;
    in_cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("w1_rsvd", o1, 11'b101_1000_0011);
    check("rsvd_u0", o0, 11'b101_0000_0010);
    tick();
    check("w1_idle", o1, 11'b000_0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
